// File: rtl/mem_slot_port.sv
// mem_slot_port: core-side front end for one time-multiplexed slot of the
// 8-way shared memory controller.
//
// The block latches one core access, presents it to the controller until the
// controller samples this slot, and captures read data at the slot-skewed
// return edge. A local 3-bit slot counter mirrors the controller's rotation.
//
// Optional build macro SLOT_SYNC_EN adds the slot_sync input, which realigns
// the local slot counter to the controller rotation.
module mem_slot_port #(
    parameter int unsigned SLOT   = 0,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk16,
    input  logic              rst_n,
`ifdef SLOT_SYNC_EN
    input  logic              slot_sync,
`endif
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] addr_,
    output logic              we_,
    output logic [DATA_W-1:0] dataIN_,
    input  logic [DATA_W-1:0] dataOUT_
);

    // Slot-counter values at which this slot is sampled / has read data back.
    localparam logic [2:0] SAMPLE_CNT = 3'(SLOT);
    localparam logic [2:0] RETURN_CNT = 3'(SLOT + 32'd3);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SLOT = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [2:0]          cnt_r;
    logic                sample_s;
    logic                return_s;
    logic                accept_s;
    logic                wr_clear_s;
    logic                rd_cap_s;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   din_r;
    logic                we_r;
    logic [DATA_W-1:0]   rdata_r;
    logic                ready_r;
    logic                done_r;

    assign sample_s = (cnt_r == SAMPLE_CNT);
    assign return_s = (cnt_r == RETURN_CNT);

    // Slot counter that tracks the controller rotation edge for edge.
`ifdef SLOT_SYNC_EN
    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 3'd0;
        end else if (slot_sync) begin
            cnt_r <= 3'd1;
        end else begin
            cnt_r <= cnt_r + 3'd1;
        end
    end
`else
    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 3'd0;
        end else begin
            cnt_r <= cnt_r + 3'd1;
        end
    end
`endif

    // Next-state decode and the per-edge action strobes.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        wr_clear_s  = 1'b0;
        rd_cap_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_WAIT_SLOT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_SLOT: begin
                if (sample_s) begin
                    if (we_r) begin
                        // Controller sees we_=1 on this edge; drop it afterwards.
                        wr_clear_s  = 1'b1;
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_WAIT_DATA;
                    end
                end else begin
                    state_nxt_s = ST_WAIT_SLOT;
                end
            end
            ST_WAIT_DATA: begin
                if (return_s) begin
                    rd_cap_s    = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT_DATA;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Access state register; reset abandons any in-flight access.
    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Controller-facing slot outputs; write enable cleared after its one sample.
    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            addr_r <= {ADDR_W{1'b0}};
            din_r  <= {DATA_W{1'b0}};
            we_r   <= 1'b0;
        end else if (accept_s) begin
            addr_r <= addr;
            din_r  <= wdata;
            we_r   <= we;
        end else if (wr_clear_s) begin
            we_r   <= 1'b0;
        end
    end

    // Read result capture at the return edge, held until the next read.
    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (rd_cap_s) begin
            rdata_r <= dataOUT_;
        end
    end

    // Registered core handshake derived from the upcoming state.
    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            ready_r <= (state_nxt_s == ST_IDLE);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    assign ready   = ready_r;
    assign done    = done_r;
    assign rdata   = rdata_r;
    assign addr_   = addr_r;
    assign we_     = we_r;
    assign dataIN_ = din_r;

endmodule

// File: tb/tb_mem_slot_port.sv
// Testbench for mem_slot_port: eight instances (SLOT 0-7) share a behavioural
// controller model; a per-slot transaction model predicts handshake timing,
// slot outputs and read data from edge-index arithmetic.
module tb_mem_slot_port;

    logic              clk16 = 1'b0;
    logic              rst_n;
    logic [7:0]        req;
    logic [7:0]        we;
    logic [11:0]       addr_i  [8];
    logic [15:0]       wdata_i [8];
    logic [7:0]        ready;
    logic [7:0]        done;
    logic [15:0]       rdata_o [8];
    logic [11:0]       addr_o  [8];
    logic [7:0]        we_o;
    logic [15:0]       din_o   [8];
    logic [15:0]       dout    [8];
`ifdef SLOT_SYNC_EN
    logic              slot_sync;
`endif

    always #5 clk16 = ~clk16;

    for (genvar g = 0; g < 8; g++) begin : g_dut
        mem_slot_port #(.SLOT(g), .ADDR_W(12), .DATA_W(16)) u_dut (
            .clk16    (clk16),
            .rst_n    (rst_n),
`ifdef SLOT_SYNC_EN
            .slot_sync(slot_sync),
`endif
            .req      (req[g]),
            .we       (we[g]),
            .addr     (addr_i[g]),
            .wdata    (wdata_i[g]),
            .ready    (ready[g]),
            .done     (done[g]),
            .rdata    (rdata_o[g]),
            .addr_    (addr_o[g]),
            .we_      (we_o[g]),
            .dataIN_  (din_o[g]),
            .dataOUT_ (dout[g])
        );
    end

    int total = 0;
    int bad   = 0;

    // Controller model state
    logic [15:0] ctrl_mem [256];
    logic [15:0] ctrl_rd  [8];
    int          wobs     [8];

    // Reference transaction model state
    int          e;
    logic [15:0] ref_mem  [256];
    bit   [7:0]  busy;
    bit   [7:0]  iswr;
    int          smp      [8];
    int          cmp      [8];
    logic [11:0] a_exp    [8];
    logic [15:0] d_exp    [8];
    logic [15:0] rd_val   [8];
    logic [15:0] rdata_exp[8];
    int          wexp     [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_req();
        req = 8'd0;
        we  = 8'd0;
    endtask

    task automatic set_req(input int s, input bit w, input logic [11:0] a, input logic [15:0] d);
        req[s]     = 1'b1;
        we[s]      = w;
        addr_i[s]  = a;
        wdata_i[s] = d;
    endtask

    task automatic model_reset();
        e    = 0;
        busy = 8'd0;
        iswr = 8'd0;
        for (int s = 0; s < 8; s++) begin
            a_exp[s]     = 12'd0;
            d_exp[s]     = 16'd0;
            rdata_exp[s] = 16'd0;
            smp[s]       = 0;
            cmp[s]       = 0;
        end
    endtask

    // One clock: check outputs after edge e-1, model controller and core for edge e.
    task automatic step(input bit rnd);
        int last;
        int sc;
        last = e - 1;
        for (int s = 0; s < 8; s++) begin
            chk($sformatf("s%0d ready", s), 32'(ready[s]), 32'(!busy[s]));
            chk($sformatf("s%0d done", s), 32'(done[s]), 32'(busy[s] && last == cmp[s]));
            chk($sformatf("s%0d we_", s), 32'(we_o[s]), 32'(busy[s] && iswr[s] && last < smp[s]));
            chk($sformatf("s%0d addr_", s), 32'(addr_o[s]), 32'(a_exp[s]));
            chk($sformatf("s%0d dataIN_", s), 32'(din_o[s]), 32'(d_exp[s]));
            chk($sformatf("s%0d rdata", s), 32'(rdata_o[s]), 32'(rdata_exp[s]));
        end
        // controller samples slot sc at edge e
        sc = e % 8;
        ctrl_rd[sc] = ctrl_mem[addr_o[sc][7:0]];
        if (we_o[sc]) begin
            ctrl_mem[addr_o[sc][7:0]] = din_o[sc];
            wobs[sc]++;
        end
        for (int s = 0; s < 8; s++) begin
            dout[s] = ((e % 8) == ((s + 3) % 8)) ? ctrl_rd[s] : 16'($urandom);
        end
        if (rnd) begin
            for (int s = 0; s < 8; s++) begin
                req[s]     = ($urandom_range(0, 2) == 0);
                we[s]      = $urandom_range(0, 1) == 1;
                addr_i[s]  = 12'($urandom_range(0, 15));
                wdata_i[s] = 16'($urandom);
            end
        end
        // reference model of edge e
        for (int s = 0; s < 8; s++) begin
            if (busy[s] && e == cmp[s] + 1) begin
                busy[s] = 1'b0;
            end else if (!busy[s] && req[s]) begin
                busy[s]  = 1'b1;
                iswr[s]  = we[s];
                a_exp[s] = addr_i[s];
                d_exp[s] = wdata_i[s];
                smp[s]   = e + ((s - (e % 8) + 7) % 8) + 1;
                cmp[s]   = smp[s] + (we[s] ? 0 : 3);
            end
            if (busy[s] && e == smp[s]) begin
                if (iswr[s]) begin
                    ref_mem[a_exp[s][7:0]] = d_exp[s];
                    wexp[s]++;
                end else begin
                    rd_val[s] = ref_mem[a_exp[s][7:0]];
                end
            end
            if (busy[s] && e == cmp[s] && !iswr[s]) begin
                rdata_exp[s] = rd_val[s];
            end
        end
        e++;
        @(negedge clk16);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    // Idle steps until slot s is free and the next edge has cnt==c.
    task automatic wait_for(input int s, input int c);
        int n;
        n = 0;
        while (!(!busy[s] && (e % 8) == c) && n < 64) begin
            step(1'b0);
            n++;
        end
        if (n >= 64) chk("wait timeout", 32'(n), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        clr_req();
        for (int s = 0; s < 8; s++) begin
            addr_i[s]  = 12'd0;
            wdata_i[s] = 16'd0;
            dout[s]    = 16'd0;
            ctrl_rd[s] = 16'd0;
            rd_val[s]  = 16'd0;
            wobs[s]    = 0;
            wexp[s]    = 0;
        end
        for (int a = 0; a < 256; a++) begin
            ctrl_mem[a] = 16'd0;
            ref_mem[a]  = 16'd0;
        end
`ifdef SLOT_SYNC_EN
        slot_sync = 1'b0;
`endif
        model_reset();
        repeat (3) @(negedge clk16);
        rst_n = 1'b1;

        // SLOT 2 write accepted at cnt==0
        set_req(2, 1'b1, 12'h064, 16'hBEEF);
        step(1'b0);
        clr_req();
        run(12);
        // SLOT 2 read of the same address accepted at cnt==1
        wait_for(2, 1);
        set_req(2, 1'b0, 12'h064, 16'h0000);
        step(1'b0);
        clr_req();
        run(12);
        chk("slot2 read beef", 32'(rdata_o[2]), 32'h0000BEEF);
        // SLOT 5 write accepted exactly on its own sample edge
        wait_for(5, 5);
        set_req(5, 1'b1, 12'h0A5, 16'h1234);
        step(1'b0);
        clr_req();
        run(14);

        // randomized traffic on all eight slots
        for (int i = 0; i < 600; i++) step(1'b1);
        clr_req();
        run(20);

        // reset during WAIT_SLOT with a pending write
        wait_for(5, 6);
        set_req(5, 1'b1, 12'h0AA, 16'hDEAD);
        step(1'b0);
        clr_req();
        step(1'b0);
        step(1'b0);
        chk("pre-reset we_", 32'(we_o[5]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("reset we_", 32'(we_o), 32'd0);
        chk("reset ready", 32'(ready), 32'hFF);
        chk("reset done", 32'(done), 32'd0);
        chk("reset addr_", 32'(addr_o[5]), 32'd0);
        @(negedge clk16);
        @(negedge clk16);
        rst_n = 1'b1;
        model_reset();
        run(16);

`ifdef SLOT_SYNC_EN
        // realign the rotation while idle, then a SLOT 3 read
        wait_for(3, 6);
        slot_sync = 1'b1;
        step(1'b0);
        slot_sync = 1'b0;
        e = e + 2;
        set_req(3, 1'b0, 12'h064, 16'h0000);
        step(1'b0);
        clr_req();
        step(1'b0);
        chk("sync we_ slot3", 32'(busy[3] && smp[3] == e), 32'd1);
        run(16);
`endif

        for (int s = 0; s < 8; s++) begin
            chk($sformatf("s%0d write count", s), 32'(wobs[s]), 32'(wexp[s]));
        end
        for (int a = 0; a < 256; a++) begin
            chk($sformatf("mem %0h", a), 32'(ctrl_mem[a]), 32'(ref_mem[a]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
